snoop_bus: RTL and testbench
============================

SNOOP_BUS -- requirements
Module: snoop_bus

Interface
REQ-001 SHALL have parameter NPROC, default 3, number of processors on the bus.
REQ-002 SHALL have parameter ADDR_W, default 5, word address width.
REQ-003 SHALL have parameter DATA_W, default 8, data width.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clock  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have req  in  NPROC  per-processor bus request, held high until its done.
REQ-006 SHALL have req_op  in  NPROC  per-processor op (0=read, 1=write).
REQ-007 SHALL have req_addr  in  NPROC*ADDR_W  per-processor address, packed.
REQ-008 SHALL have req_wdata  in  NPROC*DATA_W  per-processor write value, packed.
REQ-009 SHALL have snoop_hit  in  NPROC  holder reports a valid copy.
REQ-010 SHALL have snoop_abort  in  NPROC  holder in Modified aborts the access and supplies write-back.
REQ-011 SHALL have wb_data  in  NPROC*DATA_W  write-back value per processor.
REQ-012 SHALL have grant  out  NPROC  one-hot current owner.
REQ-013 SHALL have bus_valid, bus_op, bus_inv  out  1 each  snoop broadcast strobe, op, and invalidate.
REQ-014 SHALL have bus_addr  out  ADDR_W  broadcast address.
REQ-015 SHALL have mem_addr, mem_write, mem_wdata  out  ADDR_W/1/DATA_W  to the synchronous memory.
REQ-016 SHALL have mem_rdata  in  DATA_W  memory output, valid one cycle after mem_addr is presented.
REQ-017 SHALL have done  out  NPROC, resp_data  out  DATA_W, and resp_shared  out  1 for completion to the owner.

Function
REQ-018 SHALL implement states IDLE, SNOOP, WB, MEM, RESP.
REQ-019 IDLE: when any req is high, SHALL pick one winner, latch its op, addr, and wdata, set grant, and go to SNOOP.
REQ-020 SNOOP (1 cycle): SHALL drive bus_valid=1, bus_op, bus_addr, and bus_inv=bus_op.
REQ-021 SNOOP: SHALL mask the owner's snoop_hit/snoop_abort and OR the remaining ones.
REQ-022 SNOOP exit: any abort -> WB; otherwise -> MEM.
REQ-023 WB (1 cycle): SHALL drive mem_write=1, mem_addr=latched addr, and mem_wdata=wb_data of the lowest-index aborting processor, and SHALL latch that value as fwd_data.
REQ-024 MEM (1 cycle): SHALL drive mem_addr. For a write it SHALL drive mem_write=1 with the latched wdata; for a read it SHALL drive mem_write=0.
REQ-025 RESP (1 cycle): SHALL drive done[owner]=1 and resp_shared=OR of masked snoop_hit.
REQ-026 RESP: resp_data SHALL be fwd_data if WB occurred, else mem_rdata for reads, else 0 for writes. The block SHALL then return to IDLE and clear grant.
REQ-027 Latency from req seen in IDLE to done SHALL be 3 cycles without abort and 4 cycles with abort.
REQ-028 A new grant SHALL be issued no earlier than the cycle after RESP; back-to-back transactions SHALL therefore take 4 cycles each.
REQ-029 Req changes of the owner after grant SHALL be ignored. Req of non-owners SHALL be held pending and is never lost.
REQ-030 All outputs SHALL be 0 whenever not driven by the current state.
REQ-031 At most one grant bit SHALL be set, and at most one done bit SHALL be set.

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE and clear all outputs, latches, and fwd_data, and SHALL set the priority pointer to processor 0.
REQ-033 Reset mid-transaction SHALL abort it with no done and no further memory write. The first edge after release SHALL be IDLE evaluation.

Configuration
REQ-034 With SNOOP_BUS_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer, and the pointer becomes owner+1 (mod NPROC) on RESP.
REQ-035 Without SNOOP_BUS_RR_EN, arbitration SHALL be fixed priority with the lowest index winning, and no pointer register shall exist.

Structure
REQ-036 Package snoop_bus_pkg SHALL hold the state enum, the op encodings READ/WRITE, and the default ADDR_W/DATA_W/NPROC constants.
REQ-037 Arbitration SHALL live in sub-module rr_arbiter (req, pointer -> one-hot grant), with the fixed-priority path selected by the macro.

Verification
REQ-038 Single read, P0 addr 5'h0A, no snoop_hit, memory holds 8'h3C -> done[0] in cycle 3, resp_data=8'h3C, resp_shared=0.
REQ-039 P1 write 8'h55 to 5'h11 -> bus_inv=1 in SNOOP, mem_write with 8'h55 in MEM, done[1] in cycle 3, resp_data=0.
REQ-040 P0 reads 5'h04 while P2 asserts snoop_abort with wb_data=8'h9E -> WB writes 8'h9E to memory, done[0] in cycle 4, resp_data=8'h9E.
REQ-041 req=3'b111 held with RR enabled -> grants P0, P1, P2, P0 in that order, 4 cycles apart; without the macro -> P0 repeatedly while held.
REQ-042 reset_n low during WB -> immediate IDLE, grant=0, no done. After release, the pending req is regranted and completes normally.

Source files
------------

// File: rtl/snoop_bus_pkg.sv
// -----------------------------------------------------------------------------
// snoop_bus_pkg
// Shared definitions for the snooping bus controller: FSM state encoding,
// bus op encodings and default geometry (processor count, address and data
// widths). Imported by the interface, the arbiter and the top level.
// Optional feature macro used elsewhere: SNOOP_BUS_RR_EN (round-robin).
// -----------------------------------------------------------------------------
package snoop_bus_pkg;

   localparam int NPROC_DEF  = 3;
   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      SNOOP,
      WB,
      MEM,
      RESP
   } state_t;

endpackage

// File: rtl/snoop_bus_if.sv
// -----------------------------------------------------------------------------
// snoop_bus_if
// Bundle of all bus-side signals of the snooping bus controller.
//   master : the controller (snoop_bus) -- receives requests, snoop replies and
//            memory read data; drives grant, snoop broadcast, memory port and
//            completion.
//   slave  : the processors plus memory around it (mirror directions).
// Per-processor fields are packed, processor p at [p*W +: W].
// -----------------------------------------------------------------------------
interface snoop_bus_if
   import snoop_bus_pkg::*;
#(
   parameter int NPROC  = NPROC_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   // requests
   logic [NPROC-1:0]        req;
   logic [NPROC-1:0]        req_op;
   logic [NPROC*ADDR_W-1:0] req_addr;
   logic [NPROC*DATA_W-1:0] req_wdata;
   // snoop replies
   logic [NPROC-1:0]        snoop_hit;
   logic [NPROC-1:0]        snoop_abort;
   logic [NPROC*DATA_W-1:0] wb_data;
   // arbitration and snoop broadcast
   logic [NPROC-1:0]        grant;
   logic                    bus_valid;
   logic                    bus_op;
   logic                    bus_inv;
   logic [ADDR_W-1:0]       bus_addr;
   // synchronous memory port
   logic [ADDR_W-1:0]       mem_addr;
   logic                    mem_write;
   logic [DATA_W-1:0]       mem_wdata;
   logic [DATA_W-1:0]       mem_rdata;
   // completion
   logic [NPROC-1:0]        done;
   logic [DATA_W-1:0]       resp_data;
   logic                    resp_shared;

   modport master (
      input  req, req_op, req_addr, req_wdata,
      input  snoop_hit, snoop_abort, wb_data, mem_rdata,
      output grant, bus_valid, bus_op, bus_inv, bus_addr,
      output mem_addr, mem_write, mem_wdata,
      output done, resp_data, resp_shared
   );

   modport slave (
      output req, req_op, req_addr, req_wdata,
      output snoop_hit, snoop_abort, wb_data, mem_rdata,
      input  grant, bus_valid, bus_op, bus_inv, bus_addr,
      input  mem_addr, mem_write, mem_wdata,
      input  done, resp_data, resp_shared
   );

endinterface

// File: rtl/snoop_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational arbiter: picks one requester, returns a one-hot grant.
//   req     in  NPROC  request vector
//   pointer in  PTR_W  first index searched (only with SNOOP_BUS_RR_EN)
//   grant   out NPROC  one-hot winner, zero when no request
// SNOOP_BUS_RR_EN defined : search starts at pointer and wraps.
// SNOOP_BUS_RR_EN undefined: fixed priority, lowest index wins.
// -----------------------------------------------------------------------------
module rr_arbiter
   import snoop_bus_pkg::*;
#(
   parameter int NPROC = NPROC_DEF
`ifdef SNOOP_BUS_RR_EN
 , parameter int PTR_W = (NPROC > 1) ? $clog2(NPROC) : 1
`endif
) (
   input  logic [NPROC-1:0] req,
`ifdef SNOOP_BUS_RR_EN
   input  logic [PTR_W-1:0] pointer,
`endif
   output logic [NPROC-1:0] grant
);

`ifdef SNOOP_BUS_RR_EN
   logic found;
   int   idx;

   // NOTE: every variable written in always_comb gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NPROC; i++) begin
         idx = (int'(pointer) + i) % NPROC;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
`else
   // Scan downward so the lowest requesting index is the last one written.
   always_comb begin
      grant = '0;
      for (int i = NPROC - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/snoop_bus.sv
// -----------------------------------------------------------------------------
// snoop_bus
// Snooping bus controller for NPROC processors sharing a synchronous memory.
// One transaction at a time: IDLE (arbitrate) -> SNOOP (broadcast) ->
// [WB (write back Modified copy)] -> MEM (memory access) -> RESP (complete).
//   clock    in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      snoop_bus_if.master -- requests, snoop replies, memory port,
//            grant, broadcast and completion signals
// Macro SNOOP_BUS_RR_EN: round-robin arbitration with a priority pointer;
// undefined gives fixed lowest-index priority and no pointer register.
// -----------------------------------------------------------------------------
module snoop_bus
   import snoop_bus_pkg::*;
#(
   parameter int NPROC  = NPROC_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input logic         clock,
   input logic         reset_n,
   snoop_bus_if.master bus
);

   state_t              state;
   logic [NPROC-1:0]    grant_q, done_q, arb_grant;
   logic                op_q, wb_seen, shared_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, fwd_data;
   logic                bus_valid_q, bus_op_q, bus_inv_q;
   logic [ADDR_W-1:0]   bus_addr_q, mem_addr_q;
   logic                mem_write_q, resp_shared_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   logic                win_op;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_wdata, wb_sel;
   logic [NPROC-1:0]    hit_m, abort_m;

`ifdef SNOOP_BUS_RR_EN
   localparam int PTR_W = (NPROC > 1) ? $clog2(NPROC) : 1;
   logic [PTR_W-1:0] pointer, owner, win_idx;
`endif

   rr_arbiter #(.NPROC(NPROC)) u_arb (
      .req     (bus.req),
`ifdef SNOOP_BUS_RR_EN
      .pointer (pointer),
`endif
      .grant   (arb_grant)
   );

   // Fields of the arbitration winner.
   always_comb begin
      win_op    = OP_READ;
      win_addr  = '0;
      win_wdata = '0;
`ifdef SNOOP_BUS_RR_EN
      win_idx   = '0;
`endif
      for (int i = 0; i < NPROC; i++) begin
         if (arb_grant[i]) begin
            win_op    = bus.req_op[i];
            win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
            win_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
`ifdef SNOOP_BUS_RR_EN
            win_idx   = PTR_W'(i);
`endif
         end
      end
   end

   // The owner's own snoop reply says nothing about other copies.
   assign hit_m   = bus.snoop_hit   & ~grant_q;
   assign abort_m = bus.snoop_abort & ~grant_q;

   // Write-back source: lowest-index aborting processor.
   always_comb begin
      wb_sel = '0;
      for (int i = NPROC - 1; i >= 0; i--) begin
         if (abort_m[i]) wb_sel = bus.wb_data[i*DATA_W +: DATA_W];
      end
   end

   // Outputs are registered: each edge clears them and then loads the values
   // belonging to the state being entered.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         grant_q       <= '0;
         op_q          <= OP_READ;
         addr_q        <= '0;
         wdata_q       <= '0;
         fwd_data      <= '0;
         wb_seen       <= 1'b0;
         shared_q      <= 1'b0;
         bus_valid_q   <= 1'b0;
         bus_op_q      <= 1'b0;
         bus_inv_q     <= 1'b0;
         bus_addr_q    <= '0;
         mem_addr_q    <= '0;
         mem_write_q   <= 1'b0;
         mem_wdata_q   <= '0;
         done_q        <= '0;
         resp_shared_q <= 1'b0;
`ifdef SNOOP_BUS_RR_EN
         pointer       <= '0;
         owner         <= '0;
`endif
      end else begin
         bus_valid_q   <= 1'b0;
         bus_op_q      <= 1'b0;
         bus_inv_q     <= 1'b0;
         bus_addr_q    <= '0;
         mem_addr_q    <= '0;
         mem_write_q   <= 1'b0;
         mem_wdata_q   <= '0;
         done_q        <= '0;
         resp_shared_q <= 1'b0;
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  grant_q     <= arb_grant;
                  op_q        <= win_op;
                  addr_q      <= win_addr;
                  wdata_q     <= win_wdata;
                  wb_seen     <= 1'b0;
                  bus_valid_q <= 1'b1;
                  bus_op_q    <= win_op;
                  bus_inv_q   <= win_op;
                  bus_addr_q  <= win_addr;
`ifdef SNOOP_BUS_RR_EN
                  owner       <= win_idx;
`endif
                  state       <= SNOOP;
               end
            end
            SNOOP: begin
               shared_q   <= |hit_m;
               mem_addr_q <= addr_q;
               if (|abort_m) begin
                  mem_write_q <= 1'b1;
                  mem_wdata_q <= wb_sel;
                  fwd_data    <= wb_sel;
                  wb_seen     <= 1'b1;
                  state       <= WB;
               end else begin
                  mem_write_q <= (op_q == OP_WRITE);
                  mem_wdata_q <= (op_q == OP_WRITE) ? wdata_q : '0;
                  state       <= MEM;
               end
            end
            WB: begin
               mem_addr_q  <= addr_q;
               mem_write_q <= (op_q == OP_WRITE);
               mem_wdata_q <= (op_q == OP_WRITE) ? wdata_q : '0;
               state       <= MEM;
            end
            MEM: begin
               done_q        <= grant_q;
               resp_shared_q <= shared_q;
               state         <= RESP;
            end
            RESP: begin
               grant_q <= '0;
`ifdef SNOOP_BUS_RR_EN
               pointer <= (owner == PTR_W'(NPROC - 1)) ? '0 : owner + 1'b1;
`endif
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant       = grant_q;
   assign bus.bus_valid   = bus_valid_q;
   assign bus.bus_op      = bus_op_q;
   assign bus.bus_inv     = bus_inv_q;
   assign bus.bus_addr    = bus_addr_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_write   = mem_write_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.done        = done_q;
   assign bus.resp_shared = resp_shared_q;

   // Memory read data only arrives during RESP, so resp_data is decoded from
   // the state register rather than loaded on the edge into RESP.
   assign bus.resp_data = (state != RESP)    ? '0       :
                          wb_seen            ? fwd_data :
                          (op_q == OP_READ)  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_snoop_bus.sv
// -----------------------------------------------------------------------------
// tb_snoop_bus
// Directed bench for snoop_bus with a scoreboard: each stimulus pushes its
// expected grant, memory writes and completion into queues; a monitor on the
// falling edge pops and compares whenever the DUT shows a new grant, a memory
// write or a done. Includes a behavioural synchronous memory.
// Honours SNOOP_BUS_RR_EN for the arbitration expectations.
// -----------------------------------------------------------------------------
module tb_snoop_bus;

   typedef struct {
      logic [2:0] grant;
      logic       op;
      logic [4:0] addr;
      int         cyc;
   } exp_grant_t;

   typedef struct {
      logic [2:0] done;
      logic [7:0] data;
      logic       shared;
      int         cyc;
   } exp_done_t;

   typedef struct {
      logic [4:0] addr;
      logic [7:0] data;
   } exp_wr_t;

   logic clock = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   exp_grant_t gq[$];
   exp_done_t  dq[$];
   exp_wr_t    wq[$];
   exp_grant_t mg;
   exp_done_t  md;
   exp_wr_t    mw;
   logic [2:0] prev_grant = '0;
   logic [7:0] mem [0:31];

   snoop_bus_if #(.NPROC(3), .ADDR_W(5), .DATA_W(8)) bus_if ();

   snoop_bus #(.NPROC(3), .ADDR_W(5), .DATA_W(8)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   // Synchronous memory: read data valid the cycle after the address.
   always @(posedge clock) begin
      if (bus_if.mem_write) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
      bus_if.mem_rdata <= mem[bus_if.mem_addr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor / scoreboard.
   always @(negedge clock) begin
      if (reset_n) begin
         if (bus_if.grant != 3'b000 && prev_grant == 3'b000) begin
            if (gq.size() == 0) check("unexpected grant", 64'(bus_if.grant), 64'd0);
            else begin
               mg = gq.pop_front();
               check("grant", 64'(bus_if.grant), 64'(mg.grant));
               check("bus_valid", 64'(bus_if.bus_valid), 64'd1);
               check("bus_op", 64'(bus_if.bus_op), 64'(mg.op));
               check("bus_inv", 64'(bus_if.bus_inv), 64'(mg.op));
               check("bus_addr", 64'(bus_if.bus_addr), 64'(mg.addr));
               if (mg.cyc >= 0) check("grant cycle", 64'(cyc), 64'(mg.cyc));
            end
         end
         if (bus_if.mem_write) begin
            if (wq.size() == 0) check("unexpected mem_write", 64'(bus_if.mem_addr), 64'hFFFF);
            else begin
               mw = wq.pop_front();
               check("mem_addr", 64'(bus_if.mem_addr), 64'(mw.addr));
               check("mem_wdata", 64'(bus_if.mem_wdata), 64'(mw.data));
            end
         end
         if (bus_if.done != 3'b000) begin
            if (dq.size() == 0) check("unexpected done", 64'(bus_if.done), 64'd0);
            else begin
               md = dq.pop_front();
               check("done", 64'(bus_if.done), 64'(md.done));
               check("resp_data", 64'(bus_if.resp_data), 64'(md.data));
               check("resp_shared", 64'(bus_if.resp_shared), 64'(md.shared));
               if (md.cyc >= 0) check("done cycle", 64'(cyc), 64'(md.cyc));
            end
         end
      end
      prev_grant = bus_if.grant;
   end

   task automatic set_proc(input int p, input logic op, input logic [4:0] addr,
                           input logic [7:0] wdata);
      bus_if.req_op[p]          = op;
      bus_if.req_addr[p*5 +: 5] = addr;
      bus_if.req_wdata[p*8 +: 8] = wdata;
      bus_if.req[p]             = 1'b1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clock);
   endtask

   // Waits (bounded) for done[p], then drops the request and snoop replies.
   task automatic wait_done(input int p);
      int n;
      n = 0;
      while (!bus_if.done[p] && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!bus_if.done[p]) check("done timeout", 64'd0, 64'd1);
      bus_if.req[p]      = 1'b0;
      bus_if.snoop_hit   = '0;
      bus_if.snoop_abort = '0;
      bus_if.wb_data     = '0;
      @(negedge clock);
   endtask

   task automatic push_g(input logic [2:0] g, input logic op, input logic [4:0] a, input int c);
      gq.push_back('{grant: g, op: op, addr: a, cyc: c});
   endtask

   task automatic push_d(input logic [2:0] d, input logic [7:0] data, input logic sh, input int c);
      dq.push_back('{done: d, data: data, shared: sh, cyc: c});
   endtask

   task automatic pulse_reset();
      #1 reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int c0;
      bus_if.req         = '0;
      bus_if.req_op      = '0;
      bus_if.req_addr    = '0;
      bus_if.req_wdata   = '0;
      bus_if.snoop_hit   = '0;
      bus_if.snoop_abort = '0;
      bus_if.wb_data     = '0;
      bus_if.mem_rdata   = '0;
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      mem[5'h0A] = 8'h3C;
      mem[5'h04] = 8'h40;
      mem[5'h07] = 8'h77;
      mem[5'h01] = 8'h11;
      mem[5'h02] = 8'h22;
      mem[5'h03] = 8'h33;

      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check("reset outputs zero",
            64'({bus_if.grant, bus_if.bus_valid, bus_if.bus_op, bus_if.bus_inv,
                 bus_if.bus_addr, bus_if.mem_addr, bus_if.mem_write, bus_if.mem_wdata,
                 bus_if.done, bus_if.resp_data, bus_if.resp_shared}), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // P0 single read of 0x0A, no snoop hit.
      c0 = cyc;
      push_g(3'b001, 1'b0, 5'h0A, c0 + 1);
      push_d(3'b001, 8'h3C, 1'b0, c0 + 3);
      set_proc(0, 1'b0, 5'h0A, 8'h00);
      wait_done(0);

      // P1 write 0x55 to 0x11: invalidate broadcast, write in MEM, zero data.
      c0 = cyc;
      push_g(3'b010, 1'b1, 5'h11, c0 + 1);
      wq.push_back('{addr: 5'h11, data: 8'h55});
      push_d(3'b010, 8'h00, 1'b0, c0 + 3);
      set_proc(1, 1'b1, 5'h11, 8'h55);
      wait_done(1);
      check("mem[0x11] after write", 64'(mem[5'h11]), 64'h55);

      // P0 read with its own hit/abort asserted: must be masked out.
      c0 = cyc;
      push_g(3'b001, 1'b0, 5'h0A, c0 + 1);
      push_d(3'b001, 8'h3C, 1'b0, c0 + 3);
      bus_if.snoop_hit   = 3'b001;
      bus_if.snoop_abort = 3'b001;
      bus_if.wb_data     = 24'h0000FF;
      set_proc(0, 1'b0, 5'h0A, 8'h00);
      wait_done(0);

      // P1 read with P0 and P2 holding clean copies: shared response.
      c0 = cyc;
      push_g(3'b010, 1'b0, 5'h0A, c0 + 1);
      push_d(3'b010, 8'h3C, 1'b1, c0 + 3);
      bus_if.snoop_hit = 3'b101;
      set_proc(1, 1'b0, 5'h0A, 8'h00);
      wait_done(1);

      // P0 read of 0x04, P2 Modified aborts and writes back 0x9E.
      c0 = cyc;
      push_g(3'b001, 1'b0, 5'h04, c0 + 1);
      wq.push_back('{addr: 5'h04, data: 8'h9E});
      push_d(3'b001, 8'h9E, 1'b0, c0 + 4);
      bus_if.snoop_abort = 3'b100;
      bus_if.wb_data     = 24'h9E_0000;
      set_proc(0, 1'b0, 5'h04, 8'h00);
      wait_done(0);
      check("mem[0x04] after write-back", 64'(mem[5'h04]), 64'h9E);

      // Reset asserted during WB: transaction dropped, then regranted.
      c0 = cyc;
      push_g(3'b001, 1'b0, 5'h07, c0 + 1);
      wq.push_back('{addr: 5'h07, data: 8'hA5});
      bus_if.snoop_abort = 3'b100;
      bus_if.wb_data     = 24'hA5_0000;
      set_proc(0, 1'b0, 5'h07, 8'h00);
      wait_until(c0 + 2);
      #1 reset_n = 1'b0;
      #1;
      check("grant during reset", 64'(bus_if.grant), 64'd0);
      check("done during reset", 64'(bus_if.done), 64'd0);
      check("mem_write during reset", 64'(bus_if.mem_write), 64'd0);
      bus_if.snoop_abort = '0;
      bus_if.wb_data     = '0;
      @(negedge clock);
      c0 = cyc;
      push_g(3'b001, 1'b0, 5'h07, c0 + 1);
      push_d(3'b001, 8'h77, 1'b0, c0 + 3);
      reset_n = 1'b1;
      wait_done(0);
      check("mem[0x07] untouched by aborted WB", 64'(mem[5'h07]), 64'h77);

      // All three requesting and held: arbitration order.
      pulse_reset();
      c0 = cyc;
`ifdef SNOOP_BUS_RR_EN
      push_g(3'b001, 1'b0, 5'h01, c0 + 1);  push_d(3'b001, 8'h11, 1'b0, c0 + 3);
      push_g(3'b010, 1'b0, 5'h02, c0 + 5);  push_d(3'b010, 8'h22, 1'b0, c0 + 7);
      push_g(3'b100, 1'b0, 5'h03, c0 + 9);  push_d(3'b100, 8'h33, 1'b0, c0 + 11);
      push_g(3'b001, 1'b0, 5'h01, c0 + 13); push_d(3'b001, 8'h11, 1'b0, c0 + 15);
`else
      for (int k = 0; k < 4; k++) begin
         push_g(3'b001, 1'b0, 5'h01, c0 + 1 + 4*k);
         push_d(3'b001, 8'h11, 1'b0, c0 + 3 + 4*k);
      end
`endif
      set_proc(0, 1'b0, 5'h01, 8'h00);
      set_proc(1, 1'b0, 5'h02, 8'h00);
      set_proc(2, 1'b0, 5'h03, 8'h00);
      wait_until(c0 + 14);
      bus_if.req = '0;
      wait_until(c0 + 20);

      check("grant queue drained", 64'(gq.size()), 64'd0);
      check("done queue drained", 64'(dq.size()), 64'd0);
      check("write queue drained", 64'(wq.size()), 64'd0);
      check("idle after traffic", 64'({bus_if.grant, bus_if.done, bus_if.mem_write}), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

endmodule
